// File: rtl/carfield_mailbox_responder.sv
// -----------------------------------------------------------------------------
// carfield_mailbox_responder
//
// Purpose:
//   Memory-mapped mailbox block. It holds NumMbox mailboxes in a 4 KiB window
//   at BaseAddr. Mailbox m starts at offset m*0x10 and has four registers:
//     +0x0 DATA     32-bit read/write, byte enables honoured
//     +0x4 DOORBELL read {31'b0, db}; a write of wdata[0]=1 sets db
//     +0x8 CLEAR    a write of wdata[0]=1 clears db; reads return 0
//     +0xC IRQ_EN   bit0 read/write, upper bits read 0
//   irq_o[m] = db[m] & irq_en[m], registered.
//
// Handshake (valid/ready):
//   A request transfers on a rising edge where req_valid_i=1 and req_ready_o=1.
//   A response transfers on a rising edge where rsp_valid_o=1 and rsp_ready_i=1.
//   The response payload is held stable while it waits for rsp_ready_i.
//   The request side is ready only in IDLE, so a request is never accepted on
//   the edge where a response transfers. Peak throughput is one transaction
//   every two cycles.
//
// Ports:
//   clk_i        clock; all logic uses the rising edge
//   rst_i        synchronous active-high reset
//   req_valid_i  request valid
//   req_ready_o  request accepted this cycle (IDLE only)
//   req_we_i     1 = write, 0 = read
//   req_addr_i   byte address
//   req_wdata_i  write data
//   req_be_i     write byte enables
//   rsp_valid_o  response valid (RESP state)
//   rsp_ready_i  initiator accepts the response
//   rsp_rdata_o  read data; 0 for writes and errors
//   rsp_error_o  decode or alignment error
//   irq_o        per-mailbox interrupt
//   dbg_state_o  FSM state for observation (0 = IDLE, 1 = RESP)
// -----------------------------------------------------------------------------
module carfield_mailbox_responder #(
  parameter logic [31:0] BaseAddr = 32'h4000_0000,
  parameter int unsigned NumMbox  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [31:0]        req_addr_i,
  input  logic [31:0]        req_wdata_i,
  input  logic [3:0]         req_be_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [31:0]        rsp_rdata_o,
  output logic               rsp_error_o,
  output logic [NumMbox-1:0] irq_o,
  output logic               dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e             state_q;
  logic [31:0]        rsp_rdata_q;
  logic               rsp_error_q;

  logic [31:0]        data_q [NumMbox];
  logic [31:0]        data_d [NumMbox];
  logic [NumMbox-1:0] db_q;
  logic [NumMbox-1:0] db_d;
  logic [NumMbox-1:0] en_q;
  logic [NumMbox-1:0] en_d;
  logic [NumMbox-1:0] irq_q;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic        accept;
  logic        in_window;
  logic        aligned;
  logic        idx_ok;
  logic        dec_err;
  logic        wr_ok;
  logic [7:0]  idx;
  logic [1:0]  reg_sel;
  logic [31:0] rd_val;

  assign accept    = (state_q == IDLE) && req_valid_i;
  // BaseAddr is 4 KiB aligned, so the window test is a match on the upper bits.
  assign in_window = (req_addr_i[31:12] == BaseAddr[31:12]);
  assign aligned   = (req_addr_i[1:0] == 2'b00);
  assign idx       = req_addr_i[11:4];
  assign idx_ok    = ({24'd0, idx} < NumMbox);
  assign reg_sel   = req_addr_i[3:2];
  assign dec_err   = !(in_window && aligned && idx_ok);
  // Only decoded writes touch state. Erroring writes are dropped entirely.
  assign wr_ok     = accept && req_we_i && !dec_err;

  // Read mux. It uses the current register values, so a read never sees an
  // update from the same edge.
  always_comb begin
    rd_val = '0;
    for (int m = 0; m < int'(NumMbox); m++) begin
      if (idx == 8'(m)) begin
        case (reg_sel)
          2'd0:    rd_val = data_q[m];
          2'd1:    rd_val = {31'd0, db_q[m]};
          2'd3:    rd_val = {31'd0, en_q[m]};
          default: rd_val = '0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    db_d = db_q;
    en_d = en_q;
    for (int m = 0; m < int'(NumMbox); m++) begin
      data_d[m] = data_q[m];
    end
    if (wr_ok) begin
      for (int m = 0; m < int'(NumMbox); m++) begin
        if (idx == 8'(m)) begin
          case (reg_sel)
            2'd0: begin
              for (int b = 0; b < 4; b++) begin
                if (req_be_i[b]) data_d[m][8*b +: 8] = req_wdata_i[8*b +: 8];
              end
            end
            // Control bits live in byte 0, so they act only when be[0] is set.
            2'd1: if (req_be_i[0] && req_wdata_i[0]) db_d[m] = 1'b1;
            2'd2: if (req_be_i[0] && req_wdata_i[0]) db_d[m] = 1'b0;
            default: if (req_be_i[0]) en_d[m] = req_wdata_i[0];
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, response capture and registered interrupt
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Reset wins over a same-edge accept, so that write is discarded.
      state_q     <= IDLE;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      db_q        <= '0;
      en_q        <= '0;
      irq_q       <= '0;
      for (int m = 0; m < int'(NumMbox); m++) begin
        data_q[m] <= '0;
      end
    end else begin
      for (int m = 0; m < int'(NumMbox); m++) begin
        data_q[m] <= data_d[m];
      end
      db_q  <= db_d;
      en_q  <= en_d;
      // The interrupt uses the next values, so irq_o changes together with
      // rsp_valid_o of the write that caused the change.
      irq_q <= db_d & en_d;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            state_q     <= RESP;
            rsp_rdata_q <= (req_we_i || dec_err) ? 32'd0 : rd_val;
            rsp_error_q <= dec_err;
          end
        end
        RESP: begin
          if (rsp_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign irq_o       = irq_q;
  assign dbg_state_o = state_q;

endmodule
